sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller command/data port between two burst requesters:
//  port 0 = CPU cache line fill/flush, port 1 = video/DMA line fetch (real-time).
//  Sits between the requesters and the SDRAM controller, clocked on the SDRAM clock domain.
//  Issues one command per burst, routes the per-word get/put strobes to the owner, and
//  counts words to detect burst end. Port 1 has priority; a starvation limit protects port 0.
// PARAMETERS
//  ADDR_W      12  burst (line) address width
//  DATA_W      16  controller data word width
//  BURST_LEN    8  words per burst (get or put strobes per command), power of 2, >=2
//  MAX_CONSEC   4  max consecutive port-1 grants while port 0 waits, >=1
// PORTS
//  clk        in   1       SDRAM-domain clock
//  rst        in   1       asynchronous, active-high reset
//  pN_rd      in   1       port N (N=0,1) read-burst request, level, held until pN_gnt
//  pN_wr      in   1       port N write-burst request, level, held until pN_gnt
//  pN_addr    in   ADDR_W  port N burst address, stable while request held
//  pN_wdata   in   DATA_W  port N write word, valid when pN_put pulses
//  pN_gnt     out  1       one-cycle pulse: port N command issued
//  pN_get     out  1       read word valid on rdata (owner only)
//  pN_put     out  1       controller consumed pN_wdata (owner only)
//  rdata      out  DATA_W  read word, broadcast = ctl_dout
//  ctl_ad     out  ADDR_W  command address to controller
//  ctl_rd     out  1       one-cycle read command pulse
//  ctl_wr     out  1       one-cycle write command pulse
//  ctl_wdata  out  DATA_W  owner's pN_wdata (mux by owner)
//  ctl_dout   in   DATA_W  read word from controller
//  ctl_get    in   1       controller read-word strobe
//  ctl_put    in   1       controller write-word strobe
//  busy       out  1       burst in progress
//  owner      out  1       current/last owner port id
// BEHAVIOUR
//  Reset: state IDLE; all pN_gnt/get/put, ctl_rd/wr, busy, owner = 0; ctl_ad = 0; counters 0.
//  States: IDLE -> CMD -> XFER -> TURN -> IDLE.
//  IDLE: sample requests; choose port 1 if requesting and (p0 idle or consec<MAX_CONSEC),
//   else port 0 if requesting; none -> stay. Registers ctl_ad, owner, dir.
//  CMD (1 cycle): ctl_rd or ctl_wr = 1, pN_gnt = 1, busy = 1. Latency request->command: 2 clk.
//  Same port rd & wr both high: write served, rd remains pending.
//  XFER: each ctl_get (read) / ctl_put (write) forwarded combinationally to owner's pN_get/pN_put;
//   word counter +1; on BURST_LEN-th strobe -> TURN. Strobes of wrong direction ignored.
//  Strobes in IDLE/CMD/TURN are dropped (not forwarded, not counted).
//  TURN (1 cycle): busy = 0; requests ignored so the requester can drop its request after gnt.
//  Starvation counter consec: +1 on port-1 grant while p0 requesting (saturate at MAX_CONSEC);
//   cleared on any port-0 grant or when p0 not requesting at grant time.
//  Word counter is clog2(BURST_LEN) bits, wraps to 0 exactly at burst end.
//  No timeout: burst completes only on controller strobes; rst mid-burst aborts to IDLE, the
//   controller must be reset simultaneously.
//  Requester must not change pN_addr/pN_wdata semantics mid-burst; address is latched in IDLE.
// STRUCTURE
//  sdram_arb_pkg: state encoding (IDLE/CMD/XFER/TURN), port ids P_CPU=0/P_VID=1, dir enum.
//  Sub-module sdram_arb_pick: combinational priority+starvation choice (req0, req1, consec -> sel, valid).
//  Top: FSM, word counter, consec counter, data/strobe muxes.
// TESTING
//  p0_rd only, addr 0x123, 8 ctl_get -> ctl_rd pulse 2 clk after, ctl_ad=0x123, 8 p0_get, p1_get=0.
//  p0_wr & p1_rd same cycle -> p1 granted first; p0 granted after p1 burst + TURN.
//  p1 requesting continuously, p0 waiting, MAX_CONSEC=4 -> grants p1,p1,p1,p1,p0,p1...
//  p0_rd & p0_wr together -> ctl_wr issued; ctl_put strobes route to p0_put, ctl_wdata=p0_wdata.
//  rst asserted on 3rd word of burst -> outputs 0 immediately; next request re-arbitrates cleanly.
//  ctl_get while IDLE or during write burst -> no pN_get, word count unchanged.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, transfer direction and port ids.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_XFER = 2'd2,
        S_TURN = 2'd3
    } arb_state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } arb_dir_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_VID = 1'b1;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational port choice: video port wins unless the CPU port has already
// waited through MAX_CONSEC consecutive video grants.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int MAX_CONSEC = 4,
    parameter int CONSEC_W   = $clog2(MAX_CONSEC + 1)
) (
    input  logic                req0,
    input  logic                req1,
    input  logic [CONSEC_W-1:0] consec,
    output logic                sel,
    output logic                valid
);

    localparam logic [CONSEC_W-1:0] CONSEC_LIMIT = CONSEC_W'(MAX_CONSEC);

    always_comb begin
        valid = req0 | req1;
        sel   = P_CPU;
        if (req1 && (!req0 || (consec < CONSEC_LIMIT)))
            sel = P_VID;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port burst arbiter in front of the SDRAM controller: one command per burst,
// per-word strobes routed to the owning port, burst end found by counting words.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 8,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_get,
    output logic              p0_put,
    input  logic              p1_rd,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_get,
    output logic              p1_put,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ctl_ad,
    output logic              ctl_rd,
    output logic              ctl_wr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic [DATA_W-1:0] ctl_dout,
    input  logic              ctl_get,
    input  logic              ctl_put,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W    = $clog2(BURST_LEN);
    localparam int CONSEC_W = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0]    LAST_WORD    = CNT_W'(BURST_LEN - 1);
    localparam logic [CONSEC_W-1:0] CONSEC_LIMIT = CONSEC_W'(MAX_CONSEC);

    arb_state_t          state, state_nx;
    arb_dir_t            dir;
    logic [CNT_W-1:0]    word_cnt;
    logic [CONSEC_W-1:0] consec;
    logic                req0, req1;
    logic                pick_sel, pick_valid;
    logic                decide, strobe, sel_wr;

    assign req0   = p0_rd | p0_wr;
    assign req1   = p1_rd | p1_wr;
    assign decide = (state == S_IDLE) && pick_valid;
    assign sel_wr = (pick_sel == P_VID) ? p1_wr : p0_wr;
    // Only strobes matching the burst direction advance the transfer.
    assign strobe = (state == S_XFER) && ((dir == DIR_WR) ? ctl_put : ctl_get);

    sdram_arb_pick #(
        .MAX_CONSEC (MAX_CONSEC),
        .CONSEC_W   (CONSEC_W)
    ) u_pick (
        .req0   (req0),
        .req1   (req1),
        .consec (consec),
        .sel    (pick_sel),
        .valid  (pick_valid)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nx = S_CMD;
            S_CMD:   state_nx = S_XFER;
            S_XFER:  if (strobe && (word_cnt == LAST_WORD)) state_nx = S_TURN;
            S_TURN:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Command context is captured once at the decision; the counter wraps to 0 at burst end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            dir      <= DIR_RD;
            owner    <= P_CPU;
            ctl_ad   <= '0;
            word_cnt <= '0;
            consec   <= '0;
        end else begin
            state <= state_nx;
            if (decide) begin
                owner  <= pick_sel;
                ctl_ad <= (pick_sel == P_VID) ? p1_addr : p0_addr;
                dir    <= sel_wr ? DIR_WR : DIR_RD;
                if ((pick_sel == P_CPU) || !req0)
                    consec <= '0;
                else if (consec != CONSEC_LIMIT)
                    consec <= consec + 1'b1;
            end
            if (strobe)
                word_cnt <= word_cnt + 1'b1;
        end
    end

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        p0_get = 1'b0;
        p1_get = 1'b0;
        p0_put = 1'b0;
        p1_put = 1'b0;
        ctl_rd = 1'b0;
        ctl_wr = 1'b0;
        busy   = 1'b0;
        case (state)
            S_CMD: begin
                busy   = 1'b1;
                ctl_rd = (dir == DIR_RD);
                ctl_wr = (dir == DIR_WR);
                p0_gnt = (owner == P_CPU);
                p1_gnt = (owner == P_VID);
            end
            S_XFER: begin
                busy   = 1'b1;
                p0_get = ctl_get && (dir == DIR_RD) && (owner == P_CPU);
                p1_get = ctl_get && (dir == DIR_RD) && (owner == P_VID);
                p0_put = ctl_put && (dir == DIR_WR) && (owner == P_CPU);
                p1_put = ctl_put && (dir == DIR_WR) && (owner == P_VID);
            end
            default: ;
        endcase
    end

    assign rdata     = ctl_dout;
    assign ctl_wdata = (owner == P_VID) ? p1_wdata : p0_wdata;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, directed corner sequences
// and randomized requester/controller traffic checked against a burst-level model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int BL     = 8;
    localparam int MC     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_rd, p0_wr, p1_rd, p1_wr;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_get, p0_put, p1_gnt, p1_get, p1_put;
    logic [DATA_W-1:0] rdata, ctl_wdata, ctl_dout;
    logic [ADDR_W-1:0] ctl_ad;
    logic              ctl_rd, ctl_wr, ctl_get, ctl_put, busy, owner;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .MAX_CONSEC(MC)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_get(p0_get), .p0_put(p0_put),
        .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_get(p1_get), .p1_put(p1_put),
        .rdata(rdata), .ctl_ad(ctl_ad), .ctl_rd(ctl_rd), .ctl_wr(ctl_wr),
        .ctl_wdata(ctl_wdata), .ctl_dout(ctl_dout), .ctl_get(ctl_get), .ctl_put(ctl_put),
        .busy(busy), .owner(owner)
    );

    // stim: {p0_rd,p0_wr,p1_rd,p1_wr,ctl_get,ctl_put}
    // expv: {p0_gnt,p1_gnt,ctl_rd,ctl_wr,p0_get,p1_get,p0_put,p1_put,busy,owner}
    typedef struct {
        logic [5:0] stim;
        logic [9:0] expv;
    } vec_t;

    vec_t tab[15];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Burst-level reference: a pending command, words still owed, and a turnaround cycle.
    bit          m_cmd_due, m_turn, m_owner, m_wr;
    int          m_words_left, m_starve;
    logic [11:0] m_addr;

    bit          pend_rd[2], pend_wr[2], keep1;
    logic [11:0] req_addr[2];
    logic        g0, g1;
    int          grant_log[$];
    int          exp_log[$];
    int          get0_cnt;

    function automatic logic [9:0] dut_vec();
        return {p0_gnt, p1_gnt, ctl_rd, ctl_wr, p0_get, p1_get, p0_put, p1_put, busy, owner};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_cmd_due    = 0;
        m_turn       = 0;
        m_owner      = 0;
        m_wr         = 0;
        m_words_left = 0;
        m_starve     = 0;
        m_addr       = '0;
    endtask

    task automatic model_predict(output logic [9:0] ev);
        ev    = '0;
        ev[0] = m_owner;
        if (m_cmd_due) begin
            if (m_owner) ev[8] = 1'b1; else ev[9] = 1'b1;
            if (m_wr) ev[6] = 1'b1; else ev[7] = 1'b1;
            ev[1] = 1'b1;
        end else if (m_words_left > 0) begin
            ev[1] = 1'b1;
            if (!m_wr && ctl_get) begin
                if (m_owner) ev[4] = 1'b1; else ev[5] = 1'b1;
            end
            if (m_wr && ctl_put) begin
                if (m_owner) ev[2] = 1'b1; else ev[3] = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        bit r0, r1;
        r0 = p0_rd | p0_wr;
        r1 = p1_rd | p1_wr;
        if (m_cmd_due) begin
            m_cmd_due    = 0;
            m_words_left = BL;
        end else if (m_words_left > 0) begin
            if ((m_wr && ctl_put) || (!m_wr && ctl_get)) begin
                m_words_left--;
                if (m_words_left == 0) m_turn = 1;
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else if (r1 && (!r0 || m_starve < MC)) begin
            m_owner   = 1;
            m_wr      = p1_wr;
            m_addr    = p1_addr;
            m_starve  = r0 ? ((m_starve < MC) ? m_starve + 1 : MC) : 0;
            m_cmd_due = 1;
        end else if (r0) begin
            m_owner   = 0;
            m_wr      = p0_wr;
            m_addr    = p0_addr;
            m_starve  = 0;
            m_cmd_due = 1;
        end
    endtask

    task automatic checkOutput(input string name);
        logic [9:0]  ev, dv;
        logic [15:0] ewd;
        model_predict(ev);
        dv  = dut_vec();
        ewd = m_owner ? p1_wdata : p0_wdata;
        n_checks++;
        if (dv === ev && ctl_ad === m_addr && ctl_wdata === ewd && rdata === ctl_dout)
            n_pass++;
        else
            $display("[TB] FAIL %s cyc=%0d: vec got %b want %b, ctl_ad got %h want %h, ctl_wdata got %h want %h, rdata got %h want %h",
                     name, cyc, dv, ev, ctl_ad, m_addr, ctl_wdata, ewd, rdata, ctl_dout);
        g0 = p0_gnt;
        g1 = p1_gnt;
        if (p0_gnt || p1_gnt) grant_log.push_back((p1_gnt ? 2 : 0) + (ctl_wr ? 1 : 0));
        if (p0_get) get0_cnt++;
    endtask

    task automatic clear_inputs();
        p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        ctl_dout = '0; ctl_get = 0; ctl_put = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        pend_rd[0] = 0; pend_rd[1] = 0; pend_wr[0] = 0; pend_wr[1] = 0;
        keep1 = 0;
        grant_log.delete();
        get0_cnt = 0;
        model_reset();
        tick();
        n_checks++;
        if (dut_vec() === 10'b0 && ctl_ad === 12'h000)
            n_pass++;
        else
            $display("[TB] FAIL reset: vec got %b want %b, ctl_ad got %h want 000", dut_vec(), 10'b0, ctl_ad);
        rst = 0;
    endtask

    task automatic applyStimulus(input bit rnd, input string name);
        for (int p = 0; p < 2; p++) begin
            if (rnd && !pend_rd[p] && !pend_wr[p] && $urandom_range(3) == 0) begin
                int k;
                k = $urandom_range(2);
                pend_rd[p]  = (k != 1);
                pend_wr[p]  = (k != 0);
                req_addr[p] = 12'($urandom);
            end
        end
        if (keep1 && !pend_rd[1] && !pend_wr[1]) pend_rd[1] = 1;
        p0_rd = pend_rd[0]; p0_wr = pend_wr[0]; p0_addr = req_addr[0];
        p1_rd = pend_rd[1]; p1_wr = pend_wr[1]; p1_addr = req_addr[1];
        p0_wdata = 16'($urandom);
        p1_wdata = 16'($urandom);
        ctl_dout = 16'($urandom);
        ctl_get  = rnd ? 1'($urandom_range(1)) : 1'b1;
        ctl_put  = rnd ? 1'($urandom_range(1)) : 1'b1;
        #4;
        checkOutput(name);
        model_update();
        tick();
        // A granted write clears first; a held read stays pending behind it.
        if (g0) begin if (pend_wr[0]) pend_wr[0] = 0; else pend_rd[0] = 0; end
        if (g1) begin if (pend_wr[1]) pend_wr[1] = 0; else pend_rd[1] = 0; end
    endtask

    task automatic run_until_log(input int n, input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && grant_log.size() < n; i++)
            applyStimulus(0, name);
    endtask

    task automatic check_log(input string name);
        bit    ok;
        string a, e;
        ok = (grant_log.size() >= exp_log.size());
        a = "";
        e = "";
        foreach (exp_log[i]) begin
            e = {e, $sformatf("%0d ", exp_log[i])};
            if (ok && grant_log[i] != exp_log[i]) ok = 0;
        end
        foreach (grant_log[i]) a = {a, $sformatf("%0d ", grant_log[i])};
        n_checks++;
        if (ok) n_pass++;
        else $display("[TB] FAIL %s: grants got [ %s] want [ %s]", name, a, e);
    endtask

    initial begin
        tab[0]  = '{6'b100000, 10'b0000000000};
        tab[1]  = '{6'b100000, 10'b1010000010};
        tab[2]  = '{6'b000010, 10'b0000100010};
        tab[3]  = '{6'b000010, 10'b0000100010};
        tab[4]  = '{6'b000000, 10'b0000000010};
        tab[5]  = '{6'b000001, 10'b0000000010};
        for (int i = 6; i < 12; i++) tab[i] = '{6'b000010, 10'b0000100010};
        tab[12] = '{6'b001010, 10'b0000000000};
        tab[13] = '{6'b001010, 10'b0000000000};
        tab[14] = '{6'b001000, 10'b0110000011};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            {p0_rd, p0_wr, p1_rd, p1_wr, ctl_get, ctl_put} = tab[i].stim;
            p0_addr  = 12'h123;
            p1_addr  = 12'h3C5;
            ctl_dout = 16'(i * 17);
            #4;
            n_checks++;
            if (dut_vec() === tab[i].expv) n_pass++;
            else $display("[TB] FAIL table[%0d]: vec got %b want %b", i, dut_vec(), tab[i].expv);
            if (i == 1) begin
                n_checks++;
                if (ctl_ad === 12'h123) n_pass++;
                else $display("[TB] FAIL table_ad: ctl_ad got %h want 123", ctl_ad);
            end
            checkOutput($sformatf("table_model[%0d]", i));
            model_update();
            tick();
        end

        do_reset();
        pend_wr[0] = 1; req_addr[0] = 12'h0AB;
        pend_rd[1] = 1; req_addr[1] = 12'h3C5;
        exp_log = '{2, 1};
        run_until_log(2, 60, "p1_first");
        check_log("p1_first_order");
        for (int i = 0; i < 12; i++) applyStimulus(0, "p1_first_tail");

        do_reset();
        pend_rd[0] = 1; req_addr[0] = 12'h111;
        keep1 = 1;      req_addr[1] = 12'h222;
        exp_log = '{2, 2, 2, 2, 0, 2};
        run_until_log(6, 200, "starve");
        check_log("starve_order");

        do_reset();
        pend_rd[0] = 1; pend_wr[0] = 1; req_addr[0] = 12'h0AB;
        exp_log = '{1, 0};
        run_until_log(2, 60, "rdwr_same");
        check_log("rdwr_write_first");
        for (int i = 0; i < 12; i++) applyStimulus(0, "rdwr_tail");

        do_reset();
        pend_rd[0] = 1; req_addr[0] = 12'h055;
        for (int i = 0; i < 4; i++) applyStimulus(0, "pre_rst");
        n_checks++;
        if (get0_cnt == 2) n_pass++;
        else $display("[TB] FAIL pre_rst_words: p0_get count got %0d want 2", get0_cnt);
        ctl_get = 1; ctl_put = 1;
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (dut_vec() === 10'b0 && ctl_ad === 12'h000) n_pass++;
        else $display("[TB] FAIL rst_mid_burst: vec got %b want %b, ctl_ad got %h want 000", dut_vec(), 10'b0, ctl_ad);
        tick();
        rst = 0;
        model_reset();
        pend_rd[0] = 0; pend_wr[0] = 0;
        grant_log.delete();
        pend_rd[1] = 1; req_addr[1] = 12'h2EE;
        exp_log = '{2};
        run_until_log(1, 20, "post_rst");
        check_log("post_rst_grant");
        for (int i = 0; i < 12; i++) applyStimulus(0, "post_rst_tail");

        do_reset();
        for (int i = 0; i < 3000; i++) applyStimulus(1, "random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
